// File: rtl/byte_packer_8_32.sv
// Byte-to-word packer: finds the COM_BYTE alignment symbol, then packs four
// MSB-first bytes per 32-bit word. Unexpected gaps inside a word drop alignment.
module byte_packer_8_32 #(
    parameter logic [7:0] COM_BYTE = 8'hBC
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        aligned,
    output logic        frag_err,
    output logic [15:0] word_cnt
);

    typedef enum logic [0:0] {
        SEARCH  = 1'b0,
        ALIGNED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] word_q, word_d;
    logic [31:0] data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic        aligned_q, aligned_d;
    logic        frag_err_q, frag_err_d;
    logic [15:0] word_cnt_q, word_cnt_d;

    // Only lanes 0..2 are buffered; lane 3 goes straight to data_out with the completing byte.
    function automatic logic [23:0] put_lane(input logic [23:0] w,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
        logic [23:0] r;
        case (lane)
            2'd0:    r = {b, w[15:0]};
            2'd1:    r = {w[23:16], b, w[7:0]};
            2'd2:    r = {w[23:8], b};
            default: r = w;
        endcase
        return r;
    endfunction

    // Next-state and output decode for the alignment state machine.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        word_d      = word_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        frag_err_d  = 1'b0;
        word_cnt_d  = word_cnt_q;
        case (state_q)
            SEARCH: begin
                if (valid_in && (data_in == COM_BYTE)) begin
                    word_d  = {data_in, 16'h0000};
                    idx_d   = 2'd1;
                    state_d = ALIGNED;
                end else begin
                    idx_d   = 2'd0;
                end
            end
            ALIGNED: begin
                if (valid_in) begin
                    if (idx_q == 2'd3) begin
                        data_out_d  = {word_q, data_in};
                        valid_out_d = 1'b1;
                        word_cnt_d  = word_cnt_q + 16'd1;
                        idx_d       = 2'd0;
                    end else begin
                        word_d = put_lane(word_q, idx_q, data_in);
                        idx_d  = idx_q + 2'd1;
                    end
                end else if (idx_q != 2'd0) begin
                    // Gap inside a word: the stream lost alignment.
                    frag_err_d = 1'b1;
                    idx_d      = 2'd0;
                    state_d    = SEARCH;
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = SEARCH;
                idx_d   = 2'd0;
            end
        endcase
        aligned_d = (state_d == ALIGNED);
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q     <= SEARCH;
            idx_q       <= 2'd0;
            word_q      <= 24'h000000;
            data_out_q  <= 32'h00000000;
            valid_out_q <= 1'b0;
            aligned_q   <= 1'b0;
            frag_err_q  <= 1'b0;
            word_cnt_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            aligned_q   <= aligned_d;
            frag_err_q  <= frag_err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign aligned   = aligned_q;
    assign frag_err  = frag_err_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_byte_packer_8_32.sv
// Directed bench for byte_packer_8_32: alignment, packing, fragments, idle, reset, wrap.
module tb_byte_packer_8_32;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        aligned;
    logic        frag_err;
    logic [15:0] word_cnt;

    int n_vec = 0;
    int n_err = 0;

    byte_packer_8_32 #(.COM_BYTE(8'hBC)) dut (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .aligned  (aligned),
        .frag_err (frag_err),
        .word_cnt (word_cnt)
    );

    always #5 clk_4f = ~clk_4f;

    // Apply one byte across one rising edge; outputs are sampled 1 time unit later.
    task automatic step(input logic [7:0] b, input logic v);
        data_in  = b;
        valid_in = v;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(8'hBC, 1'b1);
        step(8'hBC, 1'b1);
        reset = 1'b0;
        n_vec++; if (data_out !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want %h", data_out, 32'h0); end
        n_vec++; if ({valid_out, aligned, frag_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want %b", {valid_out, aligned, frag_err}, 3'b000); end
        n_vec++; if (word_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h want %h", word_cnt, 16'h0); end
    endtask

    task automatic test_align;
        step(8'h55, 1'b1);
        step(8'h66, 1'b1);
        n_vec++; if (aligned !== 1'b0) begin n_err++; $display("FAIL align_ignore: got %b want %b", aligned, 1'b0); end
        step(8'hBC, 1'b1);
        n_vec++; if (aligned !== 1'b1) begin n_err++; $display("FAIL align_com: got %b want %b", aligned, 1'b1); end
        step(8'h11, 1'b1);
        step(8'h22, 1'b1);
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL align_early_valid: got %b want %b", valid_out, 1'b0); end
        step(8'h33, 1'b1);
        n_vec++; if ({valid_out, data_out, word_cnt} !== {1'b1, 32'hBC112233, 16'd1}) begin n_err++; $display("FAIL align_word: got %b %h %h want 1 bc112233 0001", valid_out, data_out, word_cnt); end
        step(8'h00, 1'b0);
        n_vec++; if ({valid_out, frag_err, aligned, data_out} !== {1'b0, 1'b0, 1'b1, 32'hBC112233}) begin n_err++; $display("FAIL align_pulse_end: got %b %b %b %h want 0 0 1 bc112233", valid_out, frag_err, aligned, data_out); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq [8];
        seq = '{8'hAA, 8'hBB, 8'hAA, 8'hCC, 8'hBB, 8'hAA, 8'hBB, 8'hEE};
        for (int i = 0; i < 8; i++) begin
            step(seq[i], 1'b1);
            if (i == 3) begin
                n_vec++; if ({valid_out, data_out, word_cnt} !== {1'b1, 32'hAABBAACC, 16'd2}) begin n_err++; $display("FAIL b2b_word1: got %b %h %h want 1 aabbaacc 0002", valid_out, data_out, word_cnt); end
            end else if (i == 4 || i == 6) begin
                n_vec++; if ({valid_out, data_out} !== {1'b0, 32'hAABBAACC}) begin n_err++; $display("FAIL b2b_hold_%0d: got %b %h want 0 aabbaacc", i, valid_out, data_out); end
            end
        end
        n_vec++; if ({valid_out, frag_err, data_out, word_cnt} !== {1'b1, 1'b0, 32'hBBAABBEE, 16'd3}) begin n_err++; $display("FAIL b2b_word2: got %b %b %h %h want 1 0 bbaabbee 0003", valid_out, frag_err, data_out, word_cnt); end
    endtask

    task automatic test_com_inside;
        step(8'h12, 1'b1);
        step(8'hBC, 1'b1);
        step(8'h34, 1'b1);
        step(8'h56, 1'b1);
        n_vec++; if ({valid_out, aligned, data_out, word_cnt} !== {1'b1, 1'b1, 32'h12BC3456, 16'd4}) begin n_err++; $display("FAIL com_inside: got %b %b %h %h want 1 1 12bc3456 0004", valid_out, aligned, data_out, word_cnt); end
    endtask

    task automatic test_fragment;
        step(8'hCC, 1'b1);
        step(8'hAA, 1'b1);
        step(8'h00, 1'b0);
        n_vec++; if ({frag_err, aligned, valid_out, data_out} !== {1'b1, 1'b0, 1'b0, 32'h12BC3456}) begin n_err++; $display("FAIL frag_pulse: got %b %b %b %h want 1 0 0 12bc3456", frag_err, aligned, valid_out, data_out); end
        step(8'h77, 1'b1);
        n_vec++; if ({frag_err, aligned} !== 2'b00) begin n_err++; $display("FAIL frag_after: got %b want %b", {frag_err, aligned}, 2'b00); end
        step(8'h11, 1'b1);
        step(8'h22, 1'b1);
        step(8'h33, 1'b1);
        n_vec++; if ({valid_out, aligned, word_cnt} !== {1'b0, 1'b0, 16'd4}) begin n_err++; $display("FAIL frag_search: got %b %b %h want 0 0 0004", valid_out, aligned, word_cnt); end
    endtask

    task automatic test_idle;
        logic saw_frag;
        saw_frag = 1'b0;
        step(8'hBC, 1'b1);
        step(8'h01, 1'b1);
        step(8'h02, 1'b1);
        step(8'h03, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 1'b0);
            saw_frag = saw_frag | frag_err;
        end
        n_vec++; if ({saw_frag, aligned, data_out} !== {1'b0, 1'b1, 32'hBC010203}) begin n_err++; $display("FAIL idle_gap: got %b %b %h want 0 1 bc010203", saw_frag, aligned, data_out); end
        step(8'hAA, 1'b1);
        step(8'hDD, 1'b1);
        step(8'hEE, 1'b1);
        step(8'hDD, 1'b1);
        n_vec++; if ({valid_out, data_out, word_cnt} !== {1'b1, 32'hAADDEEDD, 16'd6}) begin n_err++; $display("FAIL idle_word: got %b %h %h want 1 aaddeedd 0006", valid_out, data_out, word_cnt); end
    endtask

    task automatic test_reset_priority;
        step(8'hBC, 1'b1);
        step(8'hCC, 1'b1);
        step(8'hAA, 1'b1);
        reset = 1'b1;
        step(8'hDD, 1'b1);
        reset = 1'b0;
        n_vec++; if ({valid_out, aligned, frag_err, data_out, word_cnt} !== {3'b000, 32'h0, 16'h0}) begin n_err++; $display("FAIL rst_prio: got %b %b %b %h %h want 0 0 0 00000000 0000", valid_out, aligned, frag_err, data_out, word_cnt); end
        step(8'hDD, 1'b1);
        n_vec++; if ({aligned, frag_err} !== 2'b00) begin n_err++; $display("FAIL rst_search: got %b want %b", {aligned, frag_err}, 2'b00); end
    endtask

    task automatic test_wrap;
        step(8'hBC, 1'b1);
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        step(8'h01, 1'b1);
        n_vec++; if (word_cnt !== 16'd1) begin n_err++; $display("FAIL wrap_start: got %h want %h", word_cnt, 16'd1); end
        // Jump the counter close to its limit instead of streaming 64k words.
        force dut.word_cnt_q = 16'hFFFE;
        #1;
        release dut.word_cnt_q;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) step(8'(w * 4 + b), 1'b1);
            if (w == 0) begin
                n_vec++; if (word_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff: got %h want %h", word_cnt, 16'hFFFF); end
            end else if (w == 1) begin
                n_vec++; if ({valid_out, word_cnt, data_out} !== {1'b1, 16'h0000, 32'h04050607}) begin n_err++; $display("FAIL wrap_zero: got %b %h %h want 1 0000 04050607", valid_out, word_cnt, data_out); end
            end else begin
                n_vec++; if (word_cnt !== 16'h0001) begin n_err++; $display("FAIL wrap_one: got %h want %h", word_cnt, 16'h0001); end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        data_in  = 8'h00;
        valid_in = 1'b0;
        test_reset();
        test_align();
        test_back_to_back();
        test_com_inside();
        test_fragment();
        test_idle();
        test_reset_priority();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
